// File: rtl/conv_window_gen.sv
// conv_window_gen: raster pixel stream to R x C sliding windows (no padding).
//
// Keeps R-1 line buffers (one image row each, addressed by column) and an R x C
// shift window. Each accepted pixel shifts the window left by one column. The new
// right-hand column is filled from the line-buffer taps (rows 0..R-2) and the
// incoming pixel (row R-1). A window is presented only when the pixel just
// accepted sits at row >= R-1 and col >= C-1. This suppresses both the windows
// that straddle a row wrap and any window that would include stale line-buffer
// data from a previous frame.
//
// Ports:
//   clk, rst       clock; asynchronous active-low reset
//   clr            synchronous clear (line buffers keep their contents)
//   pix_in/valid   raster-order pixel input; pix_ready is the backpressure
//   A              flattened window, element (r,c) at [(r*C+c)*In_d_W +: In_d_W]
//   win_valid      A holds a complete window; win_ready is the downstream accept
//   win_last       qualifies win_valid: bottom-right window of the frame
//   frame_done     one-cycle pulse after the win_last window is accepted
module conv_window_gen #(
    parameter int unsigned In_d_W = 8,
    parameter int unsigned R      = 3,
    parameter int unsigned C      = 3,
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic [In_d_W-1:0]       pix_in,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    output logic [R*C*In_d_W-1:0]   A,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic                    win_last,
    output logic                    frame_done
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(C - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(R - 1);

    logic [CW-1:0]     col_cnt;
    logic [RW-1:0]     row_cnt;
    logic [In_d_W-1:0] win [R][C];
    // lb[R-2] holds the previous image row, lb[0] the row R-1 rows back.
    logic [In_d_W-1:0] lb  [R-1][IMG_W];

    logic pix_acc;
    logic win_acc;
    logic completes;
    logic frame_end;

    assign pix_ready = !win_valid || win_ready;
    assign pix_acc   = pix_valid && pix_ready;
    assign win_acc   = win_valid && win_ready;
    assign completes = (row_cnt >= ROW_WIN) && (col_cnt >= COL_WIN);
    assign frame_end = (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            win_valid  <= 1'b0;
            win_last   <= 1'b0;
            frame_done <= 1'b0;
            for (int r = 0; r < R; r++) begin
                for (int c = 0; c < C; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (clr) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            win_valid  <= 1'b0;
            win_last   <= 1'b0;
            frame_done <= 1'b0;
            for (int r = 0; r < R; r++) begin
                for (int c = 0; c < C; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            frame_done <= win_acc && win_last;
            if (pix_acc) begin
                if (col_cnt == COL_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
                for (int r = 0; r < R; r++) begin
                    for (int c = 0; c < C - 1; c++) begin
                        win[r][c] <= win[r][c+1];
                    end
                end
                for (int r = 0; r < R - 1; r++) begin
                    win[r][C-1] <= lb[r][col_cnt];
                end
                win[R-1][C-1] <= pix_in;
                // A simultaneous window accept is implied: pix_acc needs pix_ready.
                win_valid <= completes;
                win_last  <= completes && frame_end;
            end else if (win_acc) begin
                win_valid <= 1'b0;
                win_last  <= 1'b0;
            end
        end
    end

    // Line buffers are deliberately not reset; emission gating hides stale rows.
    always_ff @(posedge clk) begin
        if (pix_acc && !clr) begin
            for (int r = 0; r < R - 2; r++) begin
                lb[r][col_cnt] <= lb[r+1][col_cnt];
            end
            lb[R-2][col_cnt] <= pix_in;
        end
    end

    always_comb begin
        A = '0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                A[(r*C+c)*In_d_W +: In_d_W] = win[r][c];
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int NP = W * H;
    localparam int AW = 72;

    logic          clk;
    logic          rst;
    logic          clr;
    logic [7:0]    pix_in;
    logic          pix_valid;
    logic          pix_ready;
    logic [AW-1:0] A;
    logic          win_valid;
    logic          win_ready;
    logic          win_last;
    logic          frame_done;

    conv_window_gen #(
        .In_d_W(8), .R(3), .C(3), .IMG_W(W), .IMG_H(H)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .A(A), .win_valid(win_valid), .win_ready(win_ready),
        .win_last(win_last), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp;
    int n_fail;

    logic [7:0]    stream[$];
    logic [AW-1:0] exp_a[$];
    bit            exp_last[$];
    logic [AW-1:0] got_a[$];
    bit            got_last[$];
    int            fd_cyc[$];
    int            last_acc[$];
    int            stall_bad;
    int            first_wv;
    int            px12_edge;
    int            px_sent;
    bit            mon_en;
    bit            prev_stall;
    logic [AW-1:0] prev_a;
    logic          prev_last;

    // Observer: records accepted windows and stall behaviour at the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (win_valid && win_ready) begin
                got_a.push_back(A);
                got_last.push_back(win_last);
                if (win_last) last_acc.push_back(cyc + 1);
            end
            if (frame_done) fd_cyc.push_back(cyc);
            if (win_valid && first_wv < 0) first_wv = cyc;
            if (prev_stall && (A !== prev_a || win_valid !== 1'b1 || win_last !== prev_last))
                stall_bad++;
            if (win_valid && !win_ready && pix_ready) stall_bad++;
            prev_stall = win_valid && !win_ready;
            prev_a     = A;
            prev_last  = win_last;
        end
    end

    // Reference: every no-padding 3x3 window of every 5x5 frame in the stream.
    function automatic void build_expected();
        logic [AW-1:0] a;
        exp_a.delete();
        exp_last.delete();
        for (int f = 0; f < stream.size() / NP; f++)
            for (int y0 = 0; y0 <= H - 3; y0++)
                for (int x0 = 0; x0 <= W - 3; x0++) begin
                    a = '0;
                    for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++)
                            a[(r*3+c)*8 +: 8] = stream[f*NP + (y0+r)*W + x0 + c];
                    exp_a.push_back(a);
                    exp_last.push_back(y0 == H - 3 && x0 == W - 3);
                end
    endfunction

    task automatic clear_obs();
        got_a.delete();
        got_last.delete();
        fd_cyc.delete();
        last_acc.delete();
        stall_bad  = 0;
        prev_stall = 1'b0;
        first_wv   = -1;
        px12_edge  = -1;
    endtask

    task automatic reset_dut();
        mon_en    = 1'b0;
        rst       = 1'b0;
        clr       = 1'b0;
        pix_valid = 1'b0;
        pix_in    = '0;
        win_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear_obs();
        mon_en = 1'b1;
    endtask

    // vmode: 0 = always valid, 1 = random. rmode: 0 = always ready, 1 = toggle, 2 = random.
    task automatic run(input int vmode, input int rmode, input int npx, input bit wait_all);
        int k = 0;
        int budget = 0;
        while ((k < npx || (wait_all && got_a.size() < exp_a.size())) && budget < 2000) begin
            @(posedge clk);
            #1;
            pix_valid = (k < npx) && (vmode == 0 || $urandom_range(1, 0) == 1);
            if (k < npx) pix_in = stream[k];
            else pix_in = 8'h00;
            if (rmode == 0) win_ready = 1'b1;
            else if (rmode == 1) win_ready = (cyc % 2 == 0);
            else win_ready = $urandom_range(1, 0) == 1;
            @(negedge clk);
            if (pix_valid && pix_ready) begin
                if (k == 12) px12_edge = cyc + 1;
                k++;
            end
            budget++;
        end
        px_sent = k;
        if (budget >= 2000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL run_timeout: sent %0d of %0d pixels, %0d of %0d windows",
                     k, npx, got_a.size(), exp_a.size());
        end
        if (wait_all) begin
            @(posedge clk);
            #1;
            pix_valid = 1'b0;
            win_ready = 1'b1;
            repeat (3) @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_dut();
        n_cmp++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL reset_win_valid: got %b want 0", win_valid); end
        n_cmp++; if (win_last !== 1'b0) begin n_fail++; $display("FAIL reset_win_last: got %b want 0", win_last); end
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_cmp++; if (A !== '0) begin n_fail++; $display("FAIL reset_A: got %h want 0", A); end
        n_cmp++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL reset_pix_ready: got %b want 1", pix_ready); end
    endtask

    task automatic test_basic();
        logic [AW-1:0] first_ref;
        logic [AW-1:0] last_ref;
        first_ref = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
        last_ref  = {8'd24, 8'd23, 8'd22, 8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12};
        stream.delete();
        for (int k = 0; k < NP; k++) stream.push_back(8'(k));
        build_expected();
        clear_obs();
        run(0, 0, NP, 1'b1);
        n_cmp++; if (got_a.size() != 9) begin n_fail++; $display("FAIL basic_count: got %0d want 9", got_a.size()); end
        for (int i = 0; i < exp_a.size(); i++) begin
            n_cmp++;
            if (i >= got_a.size()) begin n_fail++; $display("FAIL basic_win[%0d]: missing, want %h", i, exp_a[i]); end
            else if (got_a[i] !== exp_a[i] || got_last[i] !== exp_last[i]) begin
                n_fail++;
                $display("FAIL basic_win[%0d]: got %h last=%0b want %h last=%0b", i, got_a[i], got_last[i], exp_a[i], exp_last[i]);
            end
        end
        n_cmp++; if (got_a.size() < 1 || got_a[0] !== first_ref) begin n_fail++; $display("FAIL basic_first_A: got %h want %h", got_a.size() > 0 ? got_a[0] : '0, first_ref); end
        n_cmp++; if (got_a.size() < 9 || got_a[8] !== last_ref || got_last[8] !== 1'b1) begin n_fail++; $display("FAIL basic_last_A: got %h want %h with win_last", got_a.size() > 8 ? got_a[8] : '0, last_ref); end
        n_cmp++;
        if (fd_cyc.size() != 1 || last_acc.size() != 1 || fd_cyc[0] != last_acc[0]) begin
            n_fail++;
            $display("FAIL basic_frame_done: pulses=%0d at %0d, last window accept edge %0d",
                     fd_cyc.size(), fd_cyc.size() > 0 ? fd_cyc[0] : -1, last_acc.size() > 0 ? last_acc[0] : -1);
        end
    endtask

    task automatic test_backpressure();
        stream.delete();
        for (int k = 0; k < NP; k++) stream.push_back(8'(k));
        build_expected();
        clear_obs();
        run(0, 1, NP, 1'b1);
        n_cmp++; if (got_a.size() != exp_a.size()) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", got_a.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size(); i++) begin
            n_cmp++;
            if (i >= got_a.size()) begin n_fail++; $display("FAIL bp_win[%0d]: missing, want %h", i, exp_a[i]); end
            else if (got_a[i] !== exp_a[i] || got_last[i] !== exp_last[i]) begin
                n_fail++;
                $display("FAIL bp_win[%0d]: got %h last=%0b want %h last=%0b", i, got_a[i], got_last[i], exp_a[i], exp_last[i]);
            end
        end
        n_cmp++; if (stall_bad != 0) begin n_fail++; $display("FAIL bp_stall: %0d stall violations, want 0", stall_bad); end
        n_cmp++; if (px_sent != NP) begin n_fail++; $display("FAIL bp_pixels: sent %0d want %0d", px_sent, NP); end
    endtask

    task automatic test_random_valid();
        stream.delete();
        for (int k = 0; k < NP; k++) stream.push_back(8'(k));
        build_expected();
        clear_obs();
        run(1, 0, NP, 1'b1);
        n_cmp++; if (got_a.size() != exp_a.size()) begin n_fail++; $display("FAIL rv_count: got %0d want %0d", got_a.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size(); i++) begin
            n_cmp++;
            if (i >= got_a.size()) begin n_fail++; $display("FAIL rv_win[%0d]: missing, want %h", i, exp_a[i]); end
            else if (got_a[i] !== exp_a[i] || got_last[i] !== exp_last[i]) begin
                n_fail++;
                $display("FAIL rv_win[%0d]: got %h last=%0b want %h last=%0b", i, got_a[i], got_last[i], exp_a[i], exp_last[i]);
            end
        end
        n_cmp++; if (px12_edge < 0 || first_wv != px12_edge) begin n_fail++; $display("FAIL rv_latency: first win_valid at %0d, pixel 12 accepted at edge %0d", first_wv, px12_edge); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] second_ref;
        second_ref = {8'd112, 8'd111, 8'd110, 8'd107, 8'd106, 8'd105, 8'd102, 8'd101, 8'd100};
        stream.delete();
        for (int k = 0; k < NP; k++) stream.push_back(8'(k));
        for (int k = 0; k < NP; k++) stream.push_back(8'(100 + k));
        build_expected();
        clear_obs();
        run(0, 0, 2 * NP, 1'b1);
        n_cmp++; if (got_a.size() != 18) begin n_fail++; $display("FAIL b2b_count: got %0d want 18", got_a.size()); end
        for (int i = 0; i < exp_a.size(); i++) begin
            n_cmp++;
            if (i >= got_a.size()) begin n_fail++; $display("FAIL b2b_win[%0d]: missing, want %h", i, exp_a[i]); end
            else if (got_a[i] !== exp_a[i] || got_last[i] !== exp_last[i]) begin
                n_fail++;
                $display("FAIL b2b_win[%0d]: got %h last=%0b want %h last=%0b", i, got_a[i], got_last[i], exp_a[i], exp_last[i]);
            end
        end
        n_cmp++; if (got_a.size() < 10 || got_a[9] !== second_ref) begin n_fail++; $display("FAIL b2b_second_first: got %h want %h", got_a.size() > 9 ? got_a[9] : '0, second_ref); end
        n_cmp++; if (fd_cyc.size() != 2) begin n_fail++; $display("FAIL b2b_frame_done: got %0d pulses want 2", fd_cyc.size()); end
    endtask

    task automatic test_rst_abort();
        stream.delete();
        for (int k = 0; k < NP; k++) stream.push_back(8'(k));
        build_expected();
        clear_obs();
        run(0, 0, 14, 1'b0);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        win_ready = 1'b0;
        n_cmp++; if (win_valid !== 1'b1 || A !== exp_a[1]) begin n_fail++; $display("FAIL rst_pending: got valid=%b A=%h want valid=1 A=%h", win_valid, A, exp_a[1]); end
        mon_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL rst_win_valid: got %b want 0", win_valid); end
        n_cmp++; if (A !== '0) begin n_fail++; $display("FAIL rst_A: got %h want 0", A); end
        n_cmp++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL rst_pix_ready: got %b want 1", pix_ready); end
        @(negedge clk);
        rst = 1'b1;
        clear_obs();
        mon_en = 1'b1;
        run(0, 0, NP, 1'b1);
        n_cmp++; if (got_a.size() != 9) begin n_fail++; $display("FAIL rst_restart_count: got %0d want 9", got_a.size()); end
        for (int i = 0; i < exp_a.size(); i++) begin
            n_cmp++;
            if (i >= got_a.size()) begin n_fail++; $display("FAIL rst_restart_win[%0d]: missing, want %h", i, exp_a[i]); end
            else if (got_a[i] !== exp_a[i] || got_last[i] !== exp_last[i]) begin
                n_fail++;
                $display("FAIL rst_restart_win[%0d]: got %h last=%0b want %h last=%0b", i, got_a[i], got_last[i], exp_a[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_clr_abort();
        stream.delete();
        for (int k = 0; k < NP; k++) stream.push_back(8'(k));
        build_expected();
        clear_obs();
        run(0, 0, 9, 1'b0);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        win_ready = 1'b1;
        clr       = 1'b1;
        #1;
        // Bottom window row holds the last three pixels until the clr edge.
        n_cmp++; if (A[71:48] !== {8'd8, 8'd7, 8'd6}) begin n_fail++; $display("FAIL clr_before_edge: got %h want 080706", A[71:48]); end
        @(posedge clk);
        #1;
        clr = 1'b0;
        n_cmp++; if (A !== '0 || win_valid !== 1'b0 || pix_ready !== 1'b1) begin n_fail++; $display("FAIL clr_after_edge: got A=%h valid=%b ready=%b want 0/0/1", A, win_valid, pix_ready); end
        clear_obs();
        run(0, 0, NP, 1'b1);
        n_cmp++; if (got_a.size() != 9) begin n_fail++; $display("FAIL clr_restart_count: got %0d want 9", got_a.size()); end
        for (int i = 0; i < exp_a.size(); i++) begin
            n_cmp++;
            if (i >= got_a.size()) begin n_fail++; $display("FAIL clr_restart_win[%0d]: missing, want %h", i, exp_a[i]); end
            else if (got_a[i] !== exp_a[i] || got_last[i] !== exp_last[i]) begin
                n_fail++;
                $display("FAIL clr_restart_win[%0d]: got %h last=%0b want %h last=%0b", i, got_a[i], got_last[i], exp_a[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_random_traffic();
        stream.delete();
        for (int k = 0; k < 2 * NP; k++) stream.push_back(8'($urandom_range(255, 0)));
        build_expected();
        clear_obs();
        run(1, 2, 2 * NP, 1'b1);
        n_cmp++; if (got_a.size() != exp_a.size()) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", got_a.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size(); i++) begin
            n_cmp++;
            if (i >= got_a.size()) begin n_fail++; $display("FAIL rnd_win[%0d]: missing, want %h", i, exp_a[i]); end
            else if (got_a[i] !== exp_a[i] || got_last[i] !== exp_last[i]) begin
                n_fail++;
                $display("FAIL rnd_win[%0d]: got %h last=%0b want %h last=%0b", i, got_a[i], got_last[i], exp_a[i], exp_last[i]);
            end
        end
        n_cmp++; if (stall_bad != 0) begin n_fail++; $display("FAIL rnd_stall: %0d stall violations, want 0", stall_bad); end
        n_cmp++; if (fd_cyc.size() != 2) begin n_fail++; $display("FAIL rnd_frame_done: got %0d pulses want 2", fd_cyc.size()); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        mon_en = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_random_valid();
        test_back_to_back();
        test_rst_abort();
        test_clr_abort();
        test_random_traffic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
